// File: rtl/line_reverser.sv
// line_reverser: ping-pong line buffer that replays the previous line in
// reverse pixel order, one output per accepted input pixel.
// Optional build macro LINE_REVERSER_EOL_EN adds the registered eol output
// that marks the last reversed pixel of each line.
module line_reverser #(
  parameter int DWIDTH = 33,
  parameter int AWIDTH = 11,
  parameter int DEPTH  = 1936
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [10:0]       width,
  input  logic              enable,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              valid
`ifdef LINE_REVERSER_EOL_EN
  ,
  output logic              eol
`endif
);

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  // Two line banks; the write bank and the read bank are always opposite.
  logic [DWIDTH-1:0] mem_r [0:1][0:DEPTH-1];

  logic [AWIDTH-1:0] wr_ptr_r;
  logic              wb_r;
  logic              primed_r;
  logic [10:0]       width_q_r;
  logic [DWIDTH-1:0] dout_r;
  logic              valid_r;

  logic [10:0]       width_clamp_s;
  logic [AWIDTH-1:0] last_idx_s;
  logic [AWIDTH-1:0] rd_addr_s;
  logic              line_end_s;

  // Clamp the requested width and derive the read address / end-of-line flag.
  always_comb begin
    width_clamp_s = width;
    if (width > DEPTH_W) begin
      width_clamp_s = DEPTH_W;
    end else begin
      width_clamp_s = width;
    end
    // width_q is zero only before the first sample, so the all-ones last index
    // never matches the pointer at position 0.
    last_idx_s = AWIDTH'(width_q_r - 11'd1);
    rd_addr_s  = last_idx_s - wr_ptr_r;
    line_end_s = (wr_ptr_r == last_idx_s);
  end

  // Write the incoming pixel into the active bank (banks need no reset).
  always_ff @(posedge clk) begin
    if (clken) begin
      mem_r[wb_r][wr_ptr_r] <= din;
    end
  end

  // Line position, bank select, primed flag and per-line width capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r  <= {AWIDTH{1'b0}};
      wb_r      <= 1'b0;
      primed_r  <= 1'b0;
      width_q_r <= 11'd0;
    end else if (clken) begin
      if (wr_ptr_r == {AWIDTH{1'b0}}) begin
        width_q_r <= width_clamp_s;
      end
      if (line_end_s) begin
        wr_ptr_r <= {AWIDTH{1'b0}};
        wb_r     <= ~wb_r;
        primed_r <= 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Registered reverse-order readout from the bank not being written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r  <= {DWIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (clken && primed_r) begin
      dout_r  <= mem_r[~wb_r][rd_addr_s];
      valid_r <= enable;
    end
  end

  assign dout  = dout_r;
  assign valid = valid_r;

`ifdef LINE_REVERSER_EOL_EN
  logic eol_r;

  // End-of-line marker, registered in step with valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eol_r <= 1'b0;
    end else if (clken && primed_r) begin
      eol_r <= line_end_s;
    end
  end

  assign eol = eol_r;
`endif

endmodule

// File: doc/line_reverser.md
LINE_REVERSER -- requirements
Module: line_reverser

Interface
REQ-001 Parameter DWIDTH, default 33, sets the pixel/cost word width.
REQ-002 Parameter AWIDTH, default 11, sets the address width of each line bank.
REQ-003 Parameter DEPTH, default 1936, sets the entries per line bank and the maximum line width.
REQ-004 Port clk, input, 1 bit, shall be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, shall be the asynchronous active-low reset.
REQ-006 Port clken, input, 1 bit, shall be the pixel strobe; each high cycle accepts one pixel and advances all state.
REQ-007 Port width, input, 11 bits, shall give the pixels per line.
REQ-008 Port enable, input, 1 bit, shall be copied into valid on read cycles.
REQ-009 Port din, input, DWIDTH bits, shall carry the forward-order input pixel.
REQ-010 Port dout, output, DWIDTH bits, shall carry the previous line in reverse order.
REQ-011 Port valid, output, 1 bit, shall qualify dout.
REQ-012 Port eol, output, 1 bit, shall exist only under LINE_REVERSER_EOL_EN and shall mark the last reversed pixel.

Function
REQ-013 The block shall hold two line banks (ping-pong), each DEPTH x DWIDTH, with a write-bank select wb.
REQ-014 On each clken cycle the block shall write din to bank wb at wr_ptr, then increment wr_ptr.
REQ-015 When wr_ptr equals width_q-1, the block shall wrap wr_ptr to 0, toggle wb and set primed to 1.
REQ-016 width shall be sampled into width_q on any clken cycle with wr_ptr==0; mid-line changes shall be ignored until the next line.
REQ-017 A width above DEPTH shall be clamped to DEPTH; width values 0 and 1 shall be unsupported, with behaviour undefined.
REQ-018 On each clken cycle with primed==1, the block shall register dout <= bank[!wb][width_q-1-wr_ptr].
REQ-019 On each clken cycle with primed==1, valid shall be set to enable.
REQ-020 Read latency: a pixel written at line position k shall appear on dout after the clken of position width_q-1-k of the following line.
REQ-021 Equivalently, the first reversed pixel shall appear one clock after the first clken of the next line.
REQ-022 During the first line after reset (primed==0), valid shall stay 0 and dout shall hold its reset value.
REQ-023 With clken low, all pointers, wb, primed, width_q, dout, valid and eol shall hold their values.
REQ-024 The write and the read in one cycle shall always target opposite banks, so no read/write collision is possible.

Reset
REQ-025 Reset low shall immediately clear wr_ptr, wb, primed, width_q, dout, valid and eol to 0.
REQ-026 Bank contents need not be cleared, because primed gates all output.
REQ-027 Reset asserted mid-line shall discard both the partial line and the buffered line; the first line after release shall produce no output.

Configuration
REQ-028 With LINE_REVERSER_EOL_EN defined, the eol port shall exist and shall be registered alongside valid.
REQ-029 With the macro defined, on a primed clken cycle eol shall be set to (wr_ptr==width_q-1); it shall be cleared on other primed clken cycles and held when clken is low.
REQ-030 With LINE_REVERSER_EOL_EN undefined, the eol port and its logic shall be absent; all other behaviour shall be identical.

Verification
REQ-031 Scenario: width=4, enable=1, clken always high, din=0..11 -> no valid for cycles 1-4; then dout=3,2,1,0,7,6,5,4 with valid=1.
REQ-032 Scenario: same stimulus as REQ-031, clken toggled every other cycle -> identical dout sequence; outputs hold on low-clken cycles.
REQ-033 Scenario: width changed from 4 to 6 at position 2 of line 1 -> line 1 remains 4 pixels; change takes effect at the next line start; line 2 reads out as 6 reversed pixels.
REQ-034 Scenario: rst pulsed low at position 2 of line 3 -> dout=0 and valid=0 at once; the next 4 clken cycles give valid=0; reversed output then resumes.
REQ-035 Scenario: width=1936, din=position index -> second line outputs 1935 down to 0; eol=1 only on output 0 (macro defined).
REQ-036 Scenario: enable=0 during line 2 readout -> dout still reverses correctly and valid=0 for those cycles.
